// File: rtl/flag_scoreboard_if.sv
// Decode/commit-side signal bundle for the NZCV flag scoreboard.
// The master side drives decode and writeback; the slave side is the scoreboard.
interface flag_scoreboard_if #(
    parameter int CNT_W = 3
);
    logic             ValidD;
    logic             StallD;
    logic             FlushE;
    logic [1:0]       FlagWriteD;
    logic [1:0]       NeedFlagsD;
    logic [1:0]       FlagCommitW;
    logic [3:0]       ALUFlagsW;
    logic [3:0]       FlagsD;
    logic             StallFlagD;
    logic [CNT_W-1:0] PendingNZ;
    logic [CNT_W-1:0] PendingCV;
    logic             ErrorFlag;

    modport master (
        output ValidD, StallD, FlushE, FlagWriteD, NeedFlagsD, FlagCommitW, ALUFlagsW,
        input  FlagsD, StallFlagD, PendingNZ, PendingCV, ErrorFlag
    );

    modport slave (
        input  ValidD, StallD, FlushE, FlagWriteD, NeedFlagsD, FlagCommitW, ALUFlagsW,
        output FlagsD, StallFlagD, PendingNZ, PendingCV, ErrorFlag
    );
endinterface

// File: rtl/flag_scoreboard.sv
// Decode-stage NZCV flag scoreboard: per-group pending-writer counters, architectural
// flag copy with writeback bypass, and a zero-latency flag-hazard stall.
module flag_scoreboard #(
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input logic              clk,
    input logic              rst,
    flag_scoreboard_if.slave bus
);
    // Group index: 1 = NZ, 0 = CV.
    logic [1:0][CNT_W-1:0] r_cnt;
    logic [1:0]            r_in_e;
    logic [3:0]            r_arch;
    logic                  r_error;

    logic [1:0][CNT_W-1:0] w_eff;
    logic [1:0]            w_kill;
    logic [1:0]            w_err;
    logic [1:0]            w_issue;
    logic                  w_raw_stall;
    logic                  w_full_stall;
    logic                  w_stall;

    // Count after this cycle's retirements, clamped at zero.
    function automatic logic [CNT_W-1:0] f_eff(input logic [CNT_W-1:0] cnt,
                                               input logic commit, input logic kill);
        logic [CNT_W:0] sub;
        sub = {{CNT_W{1'b0}}, commit} + {{CNT_W{1'b0}}, kill};
        if ({1'b0, cnt} > sub) begin
            return cnt - sub[CNT_W-1:0];
        end
        return '0;
    endfunction

    always_comb begin
        w_kill       = {2{bus.FlushE}} & r_in_e;
        w_eff        = '0;
        w_err        = '0;
        w_raw_stall  = 1'b0;
        w_full_stall = 1'b0;
        for (int g = 0; g < 2; g++) begin
            w_eff[g] = f_eff(r_cnt[g], bus.FlagCommitW[g], w_kill[g]);
            w_err[g] = (bus.FlagCommitW[g] | w_kill[g]) & (r_cnt[g] == '0);
            if (bus.NeedFlagsD[g] && (w_eff[g] != '0)) begin
                w_raw_stall = 1'b1;
            end
            if (bus.FlagWriteD[g] && (w_eff[g] == CNT_W'(MAX_PENDING))) begin
                w_full_stall = 1'b1;
            end
        end
    end

    assign w_stall = bus.ValidD & (w_raw_stall | w_full_stall);
    assign w_issue = {2{bus.ValidD & ~bus.StallD & ~w_stall}} & bus.FlagWriteD;

    // Issue is blocked at MAX_PENDING, so eff + issue never exceeds the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_in_e  <= '0;
            r_arch  <= '0;
            r_error <= 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                r_cnt[g] <= w_eff[g] + CNT_W'(w_issue[g]);
            end
            r_in_e <= w_issue;
            if (|w_err) begin
                r_error <= 1'b1;
            end
            if (bus.FlagCommitW[1]) begin
                r_arch[3:2] <= bus.ALUFlagsW[3:2];
            end
            if (bus.FlagCommitW[0]) begin
                r_arch[1:0] <= bus.ALUFlagsW[1:0];
            end
        end
    end

    assign bus.FlagsD     = {bus.FlagCommitW[1] ? bus.ALUFlagsW[3:2] : r_arch[3:2],
                             bus.FlagCommitW[0] ? bus.ALUFlagsW[1:0] : r_arch[1:0]};
    assign bus.StallFlagD = w_stall;
    assign bus.PendingNZ  = r_cnt[1];
    assign bus.PendingCV  = r_cnt[0];
    assign bus.ErrorFlag  = r_error;
endmodule

// File: tb/tb_flag_scoreboard.sv
// Bench for flag_scoreboard: directed scenarios then random traffic, scored against
// a behavioural model through an expected-value queue.
module tb_flag_scoreboard;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    flag_scoreboard_if #(.CNT_W(3)) bus ();

    flag_scoreboard #(.MAX_PENDING(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] flags;
        logic       stall;
        logic [2:0] pnz;
        logic [2:0] pcv;
        logic       err;
    } exp_t;

    exp_t q_exp[$];
    int   total = 0;
    int   bad   = 0;

    int         m_cnt[2];
    logic [1:0] m_ine;
    logic [3:0] m_arch;
    logic       m_err;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle, predict outputs, score them, then advance the model past the edge.
    task automatic step(input logic r, input logic v, input logic sd, input logic fe,
                        input logic [1:0] fw, input logic [1:0] nf, input logic [1:0] fc,
                        input logic [3:0] alu, input bit do_chk);
        exp_t       e;
        exp_t       got;
        int         eff[2];
        logic [1:0] kill;
        logic [1:0] iss;
        logic       stall;
        rst            = r;
        bus.ValidD     = v;
        bus.StallD     = sd;
        bus.FlushE     = fe;
        bus.FlagWriteD = fw;
        bus.NeedFlagsD = nf;
        bus.FlagCommitW = fc;
        bus.ALUFlagsW  = alu;
        stall = 1'b0;
        for (int g = 0; g < 2; g++) begin
            kill[g] = fe & m_ine[g];
            eff[g]  = m_cnt[g] - int'(fc[g]) - int'(kill[g]);
            if (eff[g] < 0) eff[g] = 0;
            if (v && nf[g] && eff[g] != 0) stall = 1'b1;
            if (v && fw[g] && eff[g] == 4) stall = 1'b1;
        end
        e.flags[3:2] = fc[1] ? alu[3:2] : m_arch[3:2];
        e.flags[1:0] = fc[0] ? alu[1:0] : m_arch[1:0];
        e.stall = stall;
        e.pnz   = 3'(m_cnt[1]);
        e.pcv   = 3'(m_cnt[0]);
        e.err   = m_err;
        q_exp.push_back(e);
        #2;
        got = q_exp.pop_front();
        if (do_chk) begin
            chk("flagsD", 8'(bus.FlagsD), 8'(got.flags));
            chk("stall", 8'(bus.StallFlagD), 8'(got.stall));
            chk("pendNZ", 8'(bus.PendingNZ), 8'(got.pnz));
            chk("pendCV", 8'(bus.PendingCV), 8'(got.pcv));
            chk("error", 8'(bus.ErrorFlag), 8'(got.err));
        end
        if (r) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            m_ine    = '0;
            m_arch   = '0;
            m_err    = 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                iss[g] = v & ~sd & ~stall & fw[g];
                if ((fc[g] || kill[g]) && m_cnt[g] == 0) m_err = 1'b1;
                m_cnt[g] = eff[g] + int'(iss[g]);
            end
            m_ine = iss;
            if (fc[1]) m_arch[3:2] = alu[3:2];
            if (fc[0]) m_arch[1:0] = alu[1:0];
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       rv, vv, sdv, fev;
        logic [1:0] fwv, nfv, fcv;
        rst = 1'b1;
        bus.ValidD = 0; bus.StallD = 0; bus.FlushE = 0;
        bus.FlagWriteD = 0; bus.NeedFlagsD = 0; bus.FlagCommitW = 0; bus.ALUFlagsW = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ine = 0; m_arch = 0; m_err = 0;
        @(posedge clk);
        #1;

        // Reset then idle reader
        step(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0);
        step(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0);
        step(0, 1, 0, 0, 2'b00, 2'b11, 2'b00, 4'h0, 1);
        chk("rst_flags", 8'(bus.FlagsD), 8'h0);

        // RAW stall on NZ, released by commit with bypass
        step(0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0, 1);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 4'h0, 1);
        chk("raw_stall", 8'(bus.StallFlagD), 8'h1);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 4'h0, 1);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 4'b1000, 1);
        chk("raw_pnz_after", 8'(bus.PendingNZ), 8'h0);

        // Group independence: CV pending, NZ reader
        step(0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 4'h0, 1);
        step(0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 4'h0, 1);
        step(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b0011, 1);

        // Flush kill of a CV writer with a CV reader in the same cycle
        step(0, 1, 0, 0, 2'b01, 2'b00, 2'b00, 4'h0, 1);
        step(0, 1, 0, 1, 2'b00, 2'b01, 2'b00, 4'h0, 1);
        chk("kill_pcv", 8'(bus.PendingCV), 8'h0);
        chk("kill_err", 8'(bus.ErrorFlag), 8'h0);

        // Saturation at MAX_PENDING, then issue alongside a commit
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0, 1);
        chk("sat_pnz", 8'(bus.PendingNZ), 8'h4);
        chk("sat_stall", 8'(bus.StallFlagD), 8'h1);
        step(0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h0, 1);
        step(0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 4'b0100, 1);
        chk("sat_pnz_hold", 8'(bus.PendingNZ), 8'h4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 4'b1100, 1);

        // Protocol error: CV commit with nothing pending
        step(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'b0101, 1);
        chk("err_set", 8'(bus.ErrorFlag), 8'h1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 2'b00, 2'b11, 2'b00, 4'h0, 1);
        chk("err_hold", 8'(bus.ErrorFlag), 8'h1);
        step(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 1);
        chk("err_clear", 8'(bus.ErrorFlag), 8'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 63) == 0);
            vv  = $urandom_range(0, 1);
            sdv = ($urandom_range(0, 5) == 0);
            fev = ($urandom_range(0, 5) == 0);
            fwv = 2'($urandom_range(0, 3));
            nfv = 2'($urandom_range(0, 3));
            for (int g = 0; g < 2; g++) begin
                fcv[g] = (m_cnt[g] > 0) ? ($urandom_range(0, 2) == 0)
                                        : ($urandom_range(0, 31) == 0);
            end
            step(rv, vv, sdv, fev, fwv, nfv, fcv, 4'($urandom_range(0, 15)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flag_scoreboard.md
Name: flag_scoreboard

Overview:
- Decode-stage reader of the NZCV condition flags, the consumer-side counterpart to the execute-stage flag writer.
- Tracks in-flight flag-writing instructions per flag group (NZ, CV) with pending counters.
- Holds the architectural flag copy, updated at commit, and supplies bypassed flags to decode.
- Stalls any conditional instruction in decode whose required flag group still has an uncommitted writer.

Parameters:
- MAX_PENDING, 4, maximum outstanding writers per flag group (at least 1).
- CNT_W, 3, counter width; must satisfy 2^CNT_W > MAX_PENDING.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ValidD  in  1  decode holds a valid instruction
- StallD  in  1  external decode stall from the hazard unit
- FlushE  in  1  instruction entering execute this cycle is killed
- FlagWriteD  in  2  decode instruction writes flags; [1]=NZ, [0]=CV
- NeedFlagsD  in  2  decode instruction's condition reads the group; [1]=NZ, [0]=CV
- FlagCommitW  in  2  writeback commits a flag write; [1]=NZ, [0]=CV
- ALUFlagsW  in  4  committed flags {N,Z,C,V}
- FlagsD  out  4  bypassed architectural flags to decode
- StallFlagD  out  1  flag-hazard stall request
- PendingNZ  out  CNT_W  outstanding NZ writers
- PendingCV  out  CNT_W  outstanding CV writers
- ErrorFlag  out  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - archFlags=0, both counters=0, inE=0, ErrorFlag=0.
  - Outputs therefore read FlagsD=0 (absent commit), StallFlagD=0, PendingNZ=PendingCV=0.
  - Reset overrides all same-cycle issue, commit and flush.
- Per group g (NZ, CV), combinational terms:
  - kill[g] = FlushE & inE[g]
  - eff[g] = cnt[g] - FlagCommitW[g] - kill[g], computed with saturation at 0.
- Stall terms:
  - rawStall = ValidD & OR over g of (NeedFlagsD[g] & eff[g] != 0)
  - fullStall = ValidD & OR over g of (FlagWriteD[g] & eff[g] == MAX_PENDING)
  - StallFlagD = rawStall | fullStall, purely combinational, zero-cycle latency.
- Issue:
  - issue[g] = ValidD & ~StallD & ~StallFlagD & FlagWriteD[g].
  - A reader that is also a writer is stall-checked first; it issues only when not stalled.
- Counter update each cycle: cnt[g] <= cnt[g] + issue[g] - FlagCommitW[g] - kill[g].
  - The net change is applied in one step, so simultaneous issue+commit leaves cnt unchanged.
  - Counters never exceed MAX_PENDING and never wrap below 0.
- inE register (groups of the writer now in execute):
  - inE <= issue each cycle.
  - A stalled or empty decode leaves a bubble, so inE=0 the next cycle.
  - FlushE kills only that single instruction; older instructions in M/W are not flushable here.
- Architectural flags:
  - On FlagCommitW[1], archFlags[3:2] <= ALUFlagsW[3:2].
  - On FlagCommitW[0], archFlags[1:0] <= ALUFlagsW[1:0].
- Bypass: FlagsD per group = ALUFlagsW bits when that group's FlagCommitW is high this cycle, else archFlags bits. A reader whose last pending writer commits this cycle is not stalled and sees the committed value.
- Errors: commit or kill on a group whose cnt is 0 sets ErrorFlag, which stays set until rst. The counter holds at 0.
- Reset mid-operation: all pending state is discarded. Any commit arriving after reset is an error per the rule above.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then ValidD=1, NeedFlagsD=2'b11.
  - Required: FlagsD=4'b0000, StallFlagD=0, PendingNZ=PendingCV=0, ErrorFlag=0.
- RAW stall with bypass:
  - Stimulus: issue a writer with FlagWriteD=2'b10. Next cycle present a reader with NeedFlagsD=2'b10; hold FlagCommitW=0 for 2 cycles, then FlagCommitW=2'b10 with ALUFlagsW=4'b1000.
  - Required: StallFlagD=1 for the 2 wait cycles. In the commit cycle StallFlagD=0 and FlagsD[3:2]=2'b10. PendingNZ goes 1->0.
- Group independence:
  - Stimulus: PendingCV=1, PendingNZ=0, reader with NeedFlagsD=2'b10.
  - Required: StallFlagD=0, no stall.
- Flush kill:
  - Stimulus: issue a CV writer; next cycle FlushE=1, no commit.
  - Required: PendingCV goes 1->0, ErrorFlag stays 0. A CV reader in that same cycle is not stalled.
- Saturation and simultaneous events:
  - Stimulus: issue 4 NZ writers back-to-back; a 5th NZ writer arrives with no commit.
  - Required: StallFlagD=1 and PendingNZ=4.
  - Then apply a commit while the 5th writer is still held: it issues and PendingNZ stays 4.
- Protocol error:
  - Stimulus: FlagCommitW=2'b01 with PendingCV=0.
  - Required: ErrorFlag=1 the next cycle and held until rst. PendingCV stays 0 and archFlags[1:0] is still updated.
